// File: rtl/program_loader.sv
// Byte-stream program loader: parses SYNC/index/count/data frames into CPU download writes.
// Optional trailing XOR checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module program_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        download_program,
    output logic [31:0] instruction_index,
    output logic [15:0] program_in,
    output logic        busy,
    output logic        load_done,
    output logic        load_error
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        S_IDLE, S_IDX_LO, S_IDX_HI, S_CNT_LO, S_CNT_HI,
        S_DATA_LO, S_DATA_HI, S_CHK, S_FINISH
    } state_t;
    localparam state_t END_ST = S_CHK;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_IDX_LO, S_IDX_HI, S_CNT_LO, S_CNT_HI,
        S_DATA_LO, S_DATA_HI, S_FINISH
    } state_t;
    localparam state_t END_ST = S_FINISH;
`endif

    state_t          state, next_state;
    logic [15:0]     start_idx;
    logic [15:0]     cnt;
    logic [15:0]     word_cnt;
    logic [7:0]      data_lo;
    logic [TW-1:0]   timer;
    logic            accept;
    logic            timeout;
    logic            last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      chk;
`endif

    assign rx_ready  = (state != S_FINISH);
    assign busy      = (state != S_IDLE);
    assign accept    = rx_valid && rx_ready;
    assign timeout   = busy && !accept && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign last_word = ((word_cnt + 16'd1) == cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (timeout) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (accept && rx_data == SYNC_BYTE) next_state = S_IDX_LO;
                S_IDX_LO:  if (accept) next_state = S_IDX_HI;
                S_IDX_HI:  if (accept) next_state = S_CNT_LO;
                S_CNT_LO:  if (accept) next_state = S_CNT_HI;
                S_CNT_HI:  if (accept) next_state = ({rx_data, cnt[7:0]} == 16'd0) ? END_ST : S_DATA_LO;
                S_DATA_LO: if (accept) next_state = S_DATA_HI;
                S_DATA_HI: if (accept) next_state = last_word ? END_ST : S_DATA_LO;
`ifdef LOADER_CHECKSUM_EN
                S_CHK:     if (accept) next_state = (rx_data == chk) ? S_FINISH : S_IDLE;
`endif
                S_FINISH:  next_state = S_IDLE;
                default:   next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_idx         <= '0;
            cnt               <= '0;
            word_cnt          <= '0;
            data_lo           <= '0;
            timer             <= '0;
            download_program  <= 1'b0;
            instruction_index <= '0;
            program_in        <= '0;
            load_done         <= 1'b0;
            load_error        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk               <= '0;
`endif
        end else begin
            load_done <= 1'b0;
            // Idle time is only counted while a frame is open.
            if (!busy || accept || timeout) timer <= '0;
            else                            timer <= timer + 1'b1;

            case (state)
                S_IDLE: if (accept && rx_data == SYNC_BYTE) begin
                    load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    chk        <= '0;
`endif
                end
                S_IDX_LO:  if (accept) start_idx[7:0]  <= rx_data;
                S_IDX_HI:  if (accept) start_idx[15:8] <= rx_data;
                S_CNT_LO:  if (accept) cnt[7:0]        <= rx_data;
                S_CNT_HI:  if (accept) begin
                    cnt[15:8] <= rx_data;
                    word_cnt  <= '0;
                end
                S_DATA_LO: if (accept) data_lo <= rx_data;
                S_DATA_HI: if (accept) begin
                    program_in        <= {rx_data, data_lo};
                    instruction_index <= {16'h0, start_idx} + {16'h0, word_cnt};
                    download_program  <= 1'b1;
                    word_cnt          <= word_cnt + 16'd1;
                end
`ifdef LOADER_CHECKSUM_EN
                // A bad checksum keeps the CPU in download until a good frame finishes.
                S_CHK: if (accept && rx_data != chk) load_error <= 1'b1;
`endif
                S_FINISH: begin
                    download_program <= 1'b0;
                    load_done        <= 1'b1;
                end
                default: ;
            endcase

`ifdef LOADER_CHECKSUM_EN
            if (accept && state inside {S_IDX_LO, S_IDX_HI, S_CNT_LO, S_CNT_HI, S_DATA_LO, S_DATA_HI})
                chk <= chk ^ rx_data;
`endif

            if (timeout) begin
                download_program <= 1'b0;
                load_error       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; works with or without LOADER_CHECKSUM_EN defined.
module tb_program_loader;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        download_program;
    logic [31:0] instruction_index;
    logic [15:0] program_in;
    logic        busy;
    logic        load_done;
    logic        load_error;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int dl_cnt   = 0;
    int snap_done;
    int snap_dl;

    program_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .download_program(download_program),
        .instruction_index(instruction_index), .program_in(program_in),
        .busy(busy), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_done) done_cnt++;
        if (download_program) dl_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 10) begin
            tick();
            n++;
        end
        if (n == 10) check("rx_ready_wait", 32'(rx_ready), 32'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_chk(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
        send(c);
`else
        c = c;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_download", 32'(download_program), 32'd0);
        check("rst_index", instruction_index, 32'd0);
        check("rst_program_in", 32'(program_in), 32'd0);
        check("rst_busy_err", {busy, load_done, load_error}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic two-word frame
        snap_done = done_cnt;
        send(8'hA5); send(8'h0A); send(8'h00); send(8'h02); send(8'h00); send(8'h20);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_dl_before", 32'(download_program), 32'd0);
        send(8'h21);
        check("basic_dl_w0", 32'(download_program), 32'd1);
        check("basic_idx_w0", instruction_index, 32'd10);
        check("basic_data_w0", 32'(program_in), 32'h2120);
        send(8'h05);
        check("basic_hold_dl", 32'(download_program), 32'd1);
        check("basic_hold_idx", instruction_index, 32'd10);
        send(8'h20);
        check("basic_idx_w1", instruction_index, 32'd11);
        check("basic_data_w1", 32'(program_in), 32'h2005);
        check("basic_dl_w1", 32'(download_program), 32'd1);
`ifndef LOADER_CHECKSUM_EN
        check("finish_rx_ready", 32'(rx_ready), 32'd0);
`endif
        send_chk(8'h2C);
        check("finish_dl_held", 32'(download_program), 32'd1);
        tick();
        check("basic_dl_fall", 32'(download_program), 32'd0);
        check("basic_done", 32'(load_done), 32'd1);
        check("basic_busy_end", 32'(busy), 32'd0);
        tick();
        check("basic_done_pulse", 32'(load_done), 32'd0);
        check("basic_done_count", 32'(done_cnt - snap_done), 32'd1);

        // Leading garbage
        send(8'h00); send(8'hFF);
        check("garbage_idle", 32'(busy), 32'd0);
        send(8'hA5); send(8'h0A); send(8'h00); send(8'h01); send(8'h00); send(8'h34); send(8'h12);
        check("garbage_idx", instruction_index, 32'd10);
        check("garbage_data", 32'(program_in), 32'h1234);
        send_chk(8'h2D);
        repeat (3) tick();
        check("garbage_err", 32'(load_error), 32'd0);
        check("garbage_dl_off", 32'(download_program), 32'd0);

        // Zero count
        snap_done = done_cnt;
        snap_dl   = dl_cnt;
        send(8'hA5); send(8'h10); send(8'h00); send(8'h00); send(8'h00);
        send_chk(8'h10);
        repeat (3) tick();
        check("zero_done", 32'(done_cnt - snap_done), 32'd1);
        check("zero_no_dl", 32'(dl_cnt - snap_dl), 32'd0);

        // SYNC value inside a frame is plain data
        send(8'hA5); send(8'h20); send(8'h00); send(8'h01); send(8'h00); send(8'hA5); send(8'hA5);
        check("sync_data_idx", instruction_index, 32'h20);
        check("sync_data_word", 32'(program_in), 32'hA5A5);
        send_chk(8'h21);
        repeat (3) tick();
        check("sync_data_err", 32'(load_error), 32'd0);

        // Timeout mid-frame
        snap_done = done_cnt;
        send(8'hA5); send(8'h0A); send(8'h00); send(8'h02); send(8'h00); send(8'h20);
        repeat (TO - 1) tick();
        check("timeout_not_yet", 32'(busy), 32'd1);
        tick();
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_err", 32'(load_error), 32'd1);
        check("timeout_dl", 32'(download_program), 32'd0);
        check("timeout_no_done", 32'(done_cnt - snap_done), 32'd0);
        send(8'hA5);
        check("sync_clears_err", 32'(load_error), 32'd0);
        send(8'h0A); send(8'h00); send(8'h00); send(8'h00);
        send_chk(8'h0A);
        repeat (3) tick();

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum keeps download asserted until a good frame finishes
        send(8'hA5); send(8'h0A); send(8'h00); send(8'h02); send(8'h00);
        send(8'h20); send(8'h21); send(8'h05); send(8'h20); send(8'h2D);
        check("badchk_err", 32'(load_error), 32'd1);
        check("badchk_busy", 32'(busy), 32'd0);
        repeat (TO + 5) tick();
        check("badchk_dl_held", 32'(download_program), 32'd1);
        send(8'hA5); send(8'h0A); send(8'h00); send(8'h02); send(8'h00);
        send(8'h20); send(8'h21); send(8'h05); send(8'h20); send(8'h2C);
        tick();
        check("goodchk_done", 32'(load_done), 32'd1);
        check("goodchk_dl_off", 32'(download_program), 32'd0);
        check("goodchk_err", 32'(load_error), 32'd0);
`endif

        // Reset mid-frame while in DATA_LO with download active
        snap_done = done_cnt;
        send(8'hA5); send(8'h0A); send(8'h00); send(8'h02); send(8'h00); send(8'h20); send(8'h21);
        check("mid_dl_on", 32'(download_program), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dl", 32'(download_program), 32'd0);
        check("mid_rst_idx", instruction_index, 32'd0);
        check("mid_rst_data", 32'(program_in), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(rx_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_no_done", 32'(done_cnt - snap_done), 32'd0);
        send(8'hA5); send(8'h0A); send(8'h00); send(8'h01); send(8'h00); send(8'h34); send(8'h12);
        check("post_rst_idx", instruction_index, 32'd10);
        check("post_rst_data", 32'(program_in), 32'h1234);
        send_chk(8'h2D);
        repeat (3) tick();
        check("post_rst_done", 32'(done_cnt - snap_done), 32'd1);
        check("post_rst_err", 32'(load_error), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
